demod_ctrl: RTL and testbench

// - Configuration/sequencing controller for the IQ demodulator (mixer + CORDIC vector stage).
// - Accepts carrier/decimation config over valid/ready, drives demod reset and parameters,

---
 rtl/demod_pkg.sv | 18 +
 rtl/demod_ctrl.sv | 177 +++++++++++++++++
 tb/tb_demod_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/demod_pkg.sv
// Shared types for the IQ demodulator control block: demod mode select and controller FSM state.
package demod_pkg;

   typedef enum logic [1:0] {
      MODE_AM      = 2'd0,
      MODE_PM      = 2'd1,
      MODE_FM      = 2'd2,
      MODE_ILLEGAL = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StFlush  = 2'd1,
      StSettle = 2'd2,
      StRun    = 2'd3
   } state_e;

endpackage

// File: rtl/demod_ctrl.sv
// Configuration/sequencing controller for one IQ demodulator channel.
// Optional squelch output is built when DEMOD_CTRL_SQUELCH_EN is defined.
module demod_ctrl
   import demod_pkg::*;
#(
   parameter int unsigned PHASE_WIDTH    = 32,
   parameter int unsigned OUTPUT_WIDTH   = 12,
   parameter int unsigned FLUSH_CYCLES   = 8,
   parameter int unsigned SETTLE_SAMPLES = 64
) (
   input  logic                    clk_in,
   input  logic                    RST,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [PHASE_WIDTH-1:0]  cfg_fre_word,
   input  logic [15:0]             cfg_factor,
   input  logic [1:0]              cfg_mode,
   output logic                    demod_rst,
   output logic [PHASE_WIDTH-1:0]  demod_fre_word,
   output logic [15:0]             demod_factor,
   input  logic                    sample_stb,
   input  logic [OUTPUT_WIDTH-1:0] am_in,
   input  logic [OUTPUT_WIDTH-1:0] pm_in,
   input  logic [OUTPUT_WIDTH-1:0] fm_in,
`ifdef DEMOD_CTRL_SQUELCH_EN
   input  logic [OUTPUT_WIDTH-1:0] sq_thresh,
   output logic                    squelch,
`endif
   output logic [OUTPUT_WIDTH-1:0] dout,
   output logic                    dout_valid,
   output logic                    locked,
   output logic                    cfg_err
);

   localparam int unsigned FlushW  = $clog2(FLUSH_CYCLES) + 1;
   localparam int unsigned SettleW = $clog2(SETTLE_SAMPLES) + 1;
   localparam logic [FlushW-1:0]  FlushLast  = FlushW'(FLUSH_CYCLES - 1);
   localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_SAMPLES - 1);

   state_e                  r_state, w_state_d;
   mode_e                   r_mode;
   logic [PHASE_WIDTH-1:0]  r_fre_word;
   logic [15:0]             r_factor;
   logic [FlushW-1:0]       r_flush_cnt, w_flush_cnt_d;
   logic [SettleW-1:0]      r_settle_cnt, w_settle_cnt_d;
   logic [OUTPUT_WIDTH-1:0] r_dout, w_dout_d, w_mux;
   logic                    r_dout_valid, w_dout_valid_d;
   logic                    r_cfg_err;
   logic                    w_handshake, w_accept, w_reject;
`ifdef DEMOD_CTRL_SQUELCH_EN
   logic                    r_squelch, w_squelch_d;
`endif

   assign cfg_ready   = (r_state != StFlush);
   assign w_handshake = cfg_valid & cfg_ready;
   assign w_accept    = w_handshake & (cfg_mode != MODE_ILLEGAL);
   assign w_reject    = w_handshake & (cfg_mode == MODE_ILLEGAL);

   always_comb begin
      w_mux = '0;
      unique case (r_mode)
         MODE_AM: w_mux = am_in;
         MODE_PM: w_mux = pm_in;
         MODE_FM: w_mux = fm_in;
         default: w_mux = '0;
      endcase
   end

   always_comb begin
      w_state_d      = r_state;
      w_flush_cnt_d  = r_flush_cnt;
      w_settle_cnt_d = r_settle_cnt;
      w_dout_d       = r_dout;
      w_dout_valid_d = 1'b0;
`ifdef DEMOD_CTRL_SQUELCH_EN
      w_squelch_d    = r_squelch;
`endif
      unique case (r_state)
         StIdle: ;
         StFlush: begin
`ifdef DEMOD_CTRL_SQUELCH_EN
            w_squelch_d = 1'b0;
`endif
            if (r_flush_cnt == '0) begin
               w_state_d      = StSettle;
               w_settle_cnt_d = '0;
            end else begin
               w_flush_cnt_d = r_flush_cnt - 1'b1;
            end
         end
         StSettle: begin
            // The strobe that completes settling is still discarded.
            if (sample_stb) begin
               if (r_settle_cnt == SettleLast) w_state_d = StRun;
               else w_settle_cnt_d = r_settle_cnt + 1'b1;
            end
         end
         StRun: begin
            if (sample_stb) begin
               w_dout_valid_d = 1'b1;
`ifdef DEMOD_CTRL_SQUELCH_EN
               if (am_in < sq_thresh) begin
                  w_dout_d    = '0;
                  w_squelch_d = 1'b1;
               end else begin
                  w_dout_d    = w_mux;
                  w_squelch_d = 1'b0;
               end
`else
               w_dout_d = w_mux;
`endif
            end
         end
         default: w_state_d = StIdle;
      endcase
      // A new configuration always wins; any coincident strobe is dropped.
      if (w_accept) begin
         w_state_d      = StFlush;
         w_flush_cnt_d  = FlushLast;
         w_dout_d       = r_dout;
         w_dout_valid_d = 1'b0;
`ifdef DEMOD_CTRL_SQUELCH_EN
         w_squelch_d    = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         r_mode       <= MODE_AM;
         r_fre_word   <= '0;
         r_factor     <= '0;
         r_flush_cnt  <= '0;
         r_settle_cnt <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_cfg_err    <= 1'b0;
`ifdef DEMOD_CTRL_SQUELCH_EN
         r_squelch    <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_mode     <= mode_e'(cfg_mode);
            r_fre_word <= cfg_fre_word;
            r_factor   <= cfg_factor;
         end
         r_flush_cnt  <= w_flush_cnt_d;
         r_settle_cnt <= w_settle_cnt_d;
         r_dout       <= w_dout_d;
         r_dout_valid <= w_dout_valid_d;
         r_cfg_err    <= w_reject;
`ifdef DEMOD_CTRL_SQUELCH_EN
         r_squelch    <= w_squelch_d;
`endif
      end
   end

   assign demod_rst      = (r_state == StIdle) || (r_state == StFlush);
   assign demod_fre_word = r_fre_word;
   assign demod_factor   = r_factor;
   assign dout           = r_dout;
   assign dout_valid     = r_dout_valid;
   assign locked         = (r_state == StRun);
   assign cfg_err        = r_cfg_err;
`ifdef DEMOD_CTRL_SQUELCH_EN
   assign squelch        = r_squelch;
`endif

endmodule

// File: tb/tb_demod_ctrl.sv
// Bench for demod_ctrl: directed sequence with random samples/strobes against a reference model.
// Squelch checks are included when DEMOD_CTRL_SQUELCH_EN is defined.
module tb_demod_ctrl;

   localparam int FLUSH  = 8;
   localparam int SETTLE = 64;

   logic        clk_in = 1'b0;
   logic        RST;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_fre_word;
   logic [15:0] cfg_factor;
   logic [1:0]  cfg_mode;
   logic        demod_rst;
   logic [31:0] demod_fre_word;
   logic [15:0] demod_factor;
   logic        sample_stb;
   logic [11:0] am_in, pm_in, fm_in;
   logic [11:0] dout;
   logic        dout_valid, locked, cfg_err;
   logic [11:0] sq_thresh;
   logic        squelch;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: remaining flush cycles, remaining strobes to discard, and run flag.
   int          m_flush_left, m_settle_left;
   bit          m_idle, m_run, m_dv, m_err, m_sq, m_accepted;
   logic [31:0] m_word;
   logic [15:0] m_factor;
   int          m_mode;
   logic [11:0] m_dout;

   demod_ctrl u_dut (
      .clk_in         (clk_in),
      .RST            (RST),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_fre_word   (cfg_fre_word),
      .cfg_factor     (cfg_factor),
      .cfg_mode       (cfg_mode),
      .demod_rst      (demod_rst),
      .demod_fre_word (demod_fre_word),
      .demod_factor   (demod_factor),
      .sample_stb     (sample_stb),
      .am_in          (am_in),
      .pm_in          (pm_in),
      .fm_in          (fm_in),
`ifdef DEMOD_CTRL_SQUELCH_EN
      .sq_thresh      (sq_thresh),
      .squelch        (squelch),
`endif
      .dout           (dout),
      .dout_valid     (dout_valid),
      .locked         (locked),
      .cfg_err        (cfg_err)
   );

`ifndef DEMOD_CTRL_SQUELCH_EN
   assign squelch = 1'b0;
`endif

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_flush_left = 0; m_settle_left = 0; m_idle = 1; m_run = 0;
      m_dv = 0; m_err = 0; m_sq = 0; m_word = '0; m_factor = '0; m_mode = 0; m_dout = '0;
   endtask

   task automatic model_step();
      bit ready, hs;
      ready = (m_flush_left == 0);
      hs    = cfg_valid && ready;
      m_err = hs && (cfg_mode == 2'd3);
      m_dv  = 0;
      m_accepted = 0;
      if (hs && cfg_mode != 2'd3) begin
         m_word = cfg_fre_word; m_factor = cfg_factor; m_mode = int'(cfg_mode);
         m_flush_left = FLUSH; m_settle_left = 0; m_idle = 0; m_run = 0; m_sq = 0;
         m_accepted = 1;
      end else if (m_flush_left > 0) begin
         m_flush_left--;
         m_sq = 0;
         if (m_flush_left == 0) m_settle_left = SETTLE;
      end else if (m_settle_left > 0) begin
         if (sample_stb) begin
            m_settle_left--;
            if (m_settle_left == 0) m_run = 1;
         end
      end else if (m_run && sample_stb) begin
         m_dv = 1;
         m_dout = (m_mode == 0) ? am_in : (m_mode == 1) ? pm_in : fm_in;
`ifdef DEMOD_CTRL_SQUELCH_EN
         m_sq = (am_in < sq_thresh);
         if (m_sq) m_dout = '0;
`endif
      end
   endtask

   task automatic check_outputs();
      check("cfg_ready",  64'(cfg_ready),      64'(m_flush_left == 0));
      check("demod_rst",  64'(demod_rst),      64'(m_idle || m_flush_left > 0));
      check("fre_word",   64'(demod_fre_word), 64'(m_word));
      check("factor",     64'(demod_factor),   64'(m_factor));
      check("locked",     64'(locked),         64'(m_run));
      check("cfg_err",    64'(cfg_err),        64'(m_err));
      check("dout_valid", 64'(dout_valid),     64'(m_dv));
      check("dout",       64'(dout),           64'(m_dout));
`ifdef DEMOD_CTRL_SQUELCH_EN
      check("squelch",    64'(squelch),        64'(m_sq));
`endif
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk_in);
      #1;
      check_outputs();
   endtask

   task automatic rand_data(input int stb_one_in);
      sample_stb = ($urandom_range(0, stb_one_in - 1) == 0);
      am_in = 12'($urandom); pm_in = 12'($urandom); fm_in = 12'($urandom);
   endtask

   task automatic run_random(input int n);
      for (int i = 0; i < n; i++) begin
         rand_data(3);
         cycle();
      end
   endtask

   task automatic run_to_lock(input string tag);
      for (int i = 0; i < 2000 && !m_run; i++) begin
         rand_data(2);
         cycle();
      end
      check(tag, 64'(locked), 64'd1);
   endtask

   task automatic send_cfg(input logic [1:0] mode, input logic [31:0] word, input logic [15:0] fac);
      cfg_valid = 1'b1; cfg_mode = mode; cfg_fre_word = word; cfg_factor = fac;
      cycle();
      cfg_valid = 1'b0;
   endtask

   initial begin
      RST = 1'b0; cfg_valid = 1'b0; cfg_fre_word = '0; cfg_factor = '0; cfg_mode = '0;
      sample_stb = 1'b0; am_in = '0; pm_in = '0; fm_in = '0; sq_thresh = '0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk_in);
      RST = 1'b1;

      // Initial AM configuration, lock, then random tracking.
      sample_stb = 1'b0;
      send_cfg(2'd0, 32'h0100_0000, 16'd16);
      run_to_lock("lock_am");
      run_random(60);

      // Illegal mode in RUN is rejected without disturbing lock or the word.
      rand_data(2);
      send_cfg(2'd3, 32'hDEAD_BEEF, 16'd99);
      sample_stb = 1'b0;
      cycle();
      check("err_keeps_word", 64'(demod_fre_word), 64'h0100_0000);
      run_random(20);

      // Reconfigure to FM in RUN with a coincident strobe, which must be dropped.
      rand_data(1);
      send_cfg(2'd2, 32'h0234_5678, 16'd32);
      check("reconf_drops_lock", 64'(locked), 64'd0);
      sample_stb = 1'b0;
      cycle();
      check("reconf_no_valid", 64'(dout_valid), 64'd0);
      run_to_lock("lock_fm");
      run_random(60);

      // Held cfg_valid stalls through FLUSH and is taken as SETTLE begins.
      send_cfg(2'd1, 32'h0000_1111, 16'd4);
      cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_fre_word = 32'h0000_2222; cfg_factor = 16'd5;
      for (int i = 0; i < 20; i++) begin
         rand_data(3);
         cycle();
         if (m_accepted) break;
      end
      check("held_cfg_taken", 64'(demod_fre_word), 64'h0000_2222);
      cfg_valid = 1'b0;
      run_to_lock("lock_pm");
      run_random(40);

      // Asynchronous reset in the middle of SETTLE.
      send_cfg(2'd0, 32'h0ABC_0000, 16'd8);
      for (int i = 0; i < 200 && !(m_settle_left > 0 && m_settle_left < SETTLE - 5); i++) begin
         rand_data(2);
         cycle();
      end
      #2;
      RST = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk_in);
      RST = 1'b1;
      sample_stb = 1'b1;
      cycle();
      run_random(5);

`ifdef DEMOD_CTRL_SQUELCH_EN
      sq_thresh = 12'h040;
      send_cfg(2'd1, 32'h0100_0000, 16'd16);
      run_to_lock("lock_sq");
      sample_stb = 1'b1; am_in = 12'h020; pm_in = 12'h355;
      cycle();
      check("sq_dout_zero", 64'(dout), 64'd0);
      check("sq_on", 64'(squelch), 64'd1);
      sample_stb = 1'b1; am_in = 12'h080; pm_in = 12'h355;
      cycle();
      check("sq_dout_pass", 64'(dout), 64'h355);
      check("sq_off", 64'(squelch), 64'd0);
      for (int i = 0; i < 60; i++) begin
         rand_data(2);
         sq_thresh = 12'($urandom);
         cycle();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
